// File: rtl/led_scan_sequencer_pkg.sv
// Shared types and constants for the LED scan sequencer.
package led_seq_pkg;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PING = 2'b10;
  localparam logic [1:0] MODE_STEP = 2'b11;

  typedef enum logic {S_IDLE, S_RUN} state_e;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  // Prescaler counter width: max(1, clog2(div)).
  function automatic int unsigned presc_width(input int unsigned div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/led_scan_sequencer_if.sv
// Control/status bundle between a controller and the LED scan sequencer.
interface led_scan_sequencer_if #(
  parameter int unsigned IDX_W = 4
);
  logic             start;
  logic             stop;
  logic [1:0]       mode;
  logic             step;
  logic             en;
  logic [IDX_W-1:0] a;
  logic             busy;
  logic             wrap;

  modport master (output start, stop, mode, step, input en, a, busy, wrap);
  modport slave  (input start, stop, mode, step, output en, a, busy, wrap);
endinterface

// File: rtl/led_scan_sequencer_tick_prescaler.sv
// Free-running divider producing one tick every TICK_DIV cycles while run is high.
module tick_prescaler
  import led_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);
  localparam int unsigned CW = presc_width(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = run && (cnt_q == LAST);

  // Count 0..TICK_DIV-1, held at zero whenever run is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!run || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/led_scan_sequencer.sv
// LED scan sequencer: drives a 4-to-16 decoder's en/a so one LED sweeps the bank.
// Optional macro SEQ_INPUT_SYNC_EN adds synchronizers and edge detection on
// start/stop/step for raw push-button inputs.
module led_scan_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned IDX_W    = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  led_scan_sequencer_if.slave bus
);
  localparam logic [IDX_W-1:0] MAX = '1;
  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  logic             start_ev, stop_ev, step_ev;
  logic             start_acc, run, tick, advance;
  state_e           state_q, state_d;
  dir_e             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic [IDX_W-1:0] a_q, a_d;
  logic             en_q, en_d, busy_q, busy_d, wrap_q, wrap_d;

`ifdef SEQ_INPUT_SYNC_EN
  logic [2:0] sync1_q, sync2_q, prev_q, ev_q;

  // Two-flop synchronizer, then a registered rising-edge pulse per input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      ev_q    <= '0;
    end else begin
      sync1_q <= {bus.start, bus.stop, bus.step};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      ev_q    <= sync2_q & ~prev_q;
    end
  end

  assign {start_ev, stop_ev, step_ev} = ev_q;
`else
  assign start_ev = bus.start;
  assign stop_ev  = bus.stop;
  assign step_ev  = bus.step;
`endif

  // stop dominates start; a restart or stop also discards this cycle's tick/step.
  assign start_acc = start_ev && !stop_ev;
  assign run       = (state_q == S_RUN) && !stop_ev && !start_acc;
  assign advance   = run && ((mode_q == MODE_STEP) ? step_ev : tick);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_acc) state_d = S_RUN;
      S_RUN:  if (stop_ev)   state_d = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and sweep context.
  always_comb begin
    mode_d = mode_q;
    dir_d  = dir_q;
    a_d    = a_q;
    wrap_d = 1'b0;
    en_d   = (state_d == S_RUN);
    busy_d = (state_d == S_RUN);
    if (start_acc) begin
      mode_d = bus.mode;
      dir_d  = DIR_UP;
      a_d    = (bus.mode == MODE_DOWN) ? MAX : '0;
    end else if (advance) begin
      unique case (mode_q)
        MODE_UP, MODE_STEP: begin
          a_d    = a_q + ONE;
          wrap_d = (a_q == MAX);
        end
        MODE_DOWN: begin
          a_d    = a_q - ONE;
          wrap_d = (a_q == '0);
        end
        MODE_PING: begin
          if (dir_q == DIR_UP) begin
            a_d = a_q + ONE;
            if (a_q + ONE == MAX) dir_d = DIR_DOWN;
          end else begin
            a_d = a_q - ONE;
            if (a_q == ONE) begin
              dir_d  = DIR_UP;
              wrap_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Output and context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_UP;
      dir_q  <= DIR_UP;
      a_q    <= '0;
      en_q   <= 1'b0;
      busy_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      a_q    <= a_d;
      en_q   <= en_d;
      busy_q <= busy_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.en   = en_q;
  assign bus.a    = a_q;
  assign bus.busy = busy_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_led_scan_sequencer.sv
// Directed bench for led_scan_sequencer with TICK_DIV=4, IDX_W=4.
module tb_led_scan_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  led_scan_sequencer_if #(.IDX_W(4)) bus ();

  led_scan_sequencer #(
    .TICK_DIV(4),
    .IDX_W   (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic       step;
    logic       en;
    logic [3:0] a;
    logic       busy;
    logic       wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic st, input logic sp, input logic [1:0] md, input logic stp,
                     input logic e, input logic [3:0] aa, input logic b, input logic w);
    vec_t v;
    v.start = st; v.stop = sp; v.mode = md; v.step = stp;
    v.en = e; v.a = aa; v.busy = b; v.wrap = w;
    vecs.push_back(v);
  endtask

  // Start a timed sweep and check every cycle against a closed-form index model.
  task automatic sweep(input logic [1:0] m, input int ncyc);
    int p, ea, ew;
    bus.start = 1'b1; bus.mode = m;
    cyc();
    bus.start = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      p = (m == 2'b10) ? (k / 4) % 30 : (k / 4) % 16;
      if (m == 2'b00)      ea = p;
      else if (m == 2'b01) ea = 15 - p;
      else                 ea = (p <= 15) ? p : 30 - p;
      ew = (k > 0 && k % 4 == 0 && p == 0) ? 1 : 0;
      check($sformatf("sweep%0d_en_k%0d", m, k), 32'(bus.en), 1);
      check($sformatf("sweep%0d_busy_k%0d", m, k), 32'(bus.busy), 1);
      check($sformatf("sweep%0d_a_k%0d", m, k), 32'(bus.a), 32'(ea));
      check($sformatf("sweep%0d_wrap_k%0d", m, k), 32'(bus.wrap), 32'(ew));
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int av;
    bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 2'b00; bus.step = 1'b0;
    #12;
    check("rst_en", 32'(bus.en), 0);
    check("rst_a", 32'(bus.a), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_wrap", 32'(bus.wrap), 0);
    rst_n = 1'b1;
    cyc();
    cyc();
    check("idle_en", 32'(bus.en), 0);

    sweep(2'b00, 68);
    sweep(2'b01, 68);
    sweep(2'b10, 248);

    // Manual step, stop/restart and stop-vs-start corner cases.
    add(1, 0, 3, 0, 1, 0, 1, 0);
    av = 0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 9; j++) add(0, 0, (j == 4) ? 2'b00 : 2'b11, 0, 1, 4'(av), 1, 0);
      av++;
      add(0, 0, 3, 1, 1, 4'(av), 1, 0);
    end
    for (int i = 0; i < 4; i++) begin
      av++;
      add(0, 0, 3, 1, 1, 4'(av), 1, 0);
    end
    add(0, 1, 3, 0, 0, 7, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, 7, 0, 0);
    add(1, 1, 0, 0, 0, 7, 0, 0);
    add(0, 0, 0, 0, 0, 7, 0, 0);
    add(1, 0, 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 1, 0, 1, 0);
    add(0, 0, 0, 0, 1, 1, 1, 0);
    add(1, 0, 3, 0, 1, 0, 1, 0);
    add(0, 0, 3, 1, 1, 1, 1, 0);
    add(0, 1, 3, 1, 0, 1, 0, 0);
    add(1, 0, 3, 0, 1, 0, 1, 0);
    for (int i = 1; i <= 16; i++) add(0, 0, 3, 1, 1, 4'(i), 1, (i == 16) ? 1'b1 : 1'b0);
    add(0, 0, 3, 0, 1, 0, 1, 0);
    add(0, 1, 3, 0, 0, 0, 0, 0);
    add(0, 0, 3, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      bus.start = vecs[i].start; bus.stop = vecs[i].stop;
      bus.mode  = vecs[i].mode;  bus.step = vecs[i].step;
      cyc();
      check($sformatf("vec%0d_en", i), 32'(bus.en), 32'(vecs[i].en));
      check($sformatf("vec%0d_a", i), 32'(bus.a), 32'(vecs[i].a));
      check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_wrap", i), 32'(bus.wrap), 32'(vecs[i].wrap));
    end
    bus.start = 1'b0; bus.stop = 1'b0; bus.step = 1'b0; bus.mode = 2'b00;

    // Asynchronous reset in the middle of an up sweep.
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (36) cyc();
    check("pre_rst_a", 32'(bus.a), 9);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_en", 32'(bus.en), 0);
    check("async_rst_a", 32'(bus.a), 0);
    check("async_rst_busy", 32'(bus.busy), 0);
    check("async_rst_wrap", 32'(bus.wrap), 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check($sformatf("post_rst_en%0d", i), 32'(bus.en), 0);
      check($sformatf("post_rst_busy%0d", i), 32'(bus.busy), 0);
      check($sformatf("post_rst_a%0d", i), 32'(bus.a), 0);
    end
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check("restart_en", 32'(bus.en), 1);
    check("restart_a", 32'(bus.a), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
